// File: rtl/nibble_pkg.sv
// nibble_pkg: shared definitions for the nibble assembler slice.
//   NIB_W        - nibble width
//   BYTE_W       - assembled byte width (two nibbles)
//   state_t      - pairing FSM state (waiting for low or high nibble)
//   fifo_entry_t - one buffered output byte with its frame tags
package nibble_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 2 * NIB_W;

    typedef enum logic {
        LO_WAIT = 1'b0,
        HI_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
        logic              partial;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small synchronous FIFO with registered head presentation.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, push_data - write request and entry (ignored when full)
//   pop         - read request (ignored when empty)
//   pop_data    - head entry; while empty it holds the last popped entry
//   full, empty - occupancy flags, decoded from the occupancy register
module byte_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] hold;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // An empty FIFO keeps showing the most recently popped entry so the
    // downstream data lines do not change when nothing is valid.
    assign pop_data = empty ? hold : mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                hold   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nibble_assembler.sv
// nibble_assembler: pairs a low-nibble-first stream into bytes, buffers
// them in a small FIFO and tags frame ends and odd-length (padded) bytes.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   nib_in, nib_valid, nib_last    - input nibble stream
//   nib_ready                      - nibble accepted this cycle when valid
//   byte_out, byte_last, byte_partial, byte_valid - FIFO head
//   byte_ready                     - downstream accepts the head byte
//   byte_count                     - bytes pushed since reset (wrapping)
//   odd_err, clr_err               - sticky padded-byte flag and its clear
module nibble_assembler #(
    parameter int NIB_W      = nibble_pkg::NIB_W,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NIB_W-1:0]   nib_in,
    input  logic               nib_valid,
    input  logic               nib_last,
    output logic               nib_ready,
    output logic [2*NIB_W-1:0] byte_out,
    output logic               byte_last,
    output logic               byte_partial,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic [CNT_W-1:0]   byte_count,
    output logic               odd_err,
    input  logic               clr_err
);

    import nibble_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic [NIB_W-1:0] lo_q;
    logic [NIB_W-1:0] lo_d;
    logic             run_q;
    logic             push;
    logic             set_err;
    logic             accept;
    logic             pop;
    logic             full;
    logic             empty;
    fifo_entry_t      push_entry;
    fifo_entry_t      head;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    // run_q is low during reset and rises on the first clock after release,
    // keeping nib_ready purely register-decoded.
    assign nib_ready  = run_q && !full;
    assign accept     = nib_valid && nib_ready;
    assign byte_valid = !empty;
    assign pop        = byte_valid && byte_ready;

    // Pairing FSM: a low nibble is parked until its high partner arrives;
    // a frame ending on a low nibble is closed with a zero-padded byte.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        push       = 1'b0;
        set_err    = 1'b0;
        push_entry = '0;
        if (accept) begin
            unique case (state_q)
                LO_WAIT: begin
                    if (nib_last) begin
                        push               = 1'b1;
                        set_err            = 1'b1;
                        push_entry.data    = {{NIB_W{1'b0}}, nib_in};
                        push_entry.last    = 1'b1;
                        push_entry.partial = 1'b1;
                    end else begin
                        lo_d    = nib_in;
                        state_d = HI_WAIT;
                    end
                end
                HI_WAIT: begin
                    push               = 1'b1;
                    push_entry.data    = {nib_in, lo_q};
                    push_entry.last    = nib_last;
                    push_entry.partial = 1'b0;
                    state_d            = LO_WAIT;
                end
                default: state_d = LO_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LO_WAIT;
            lo_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            run_q   <= 1'b1;
        end
    end

    // A padded push in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (set_err) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign byte_out     = head.data;
    assign byte_last    = head.last;
    assign byte_partial = head.partial;
    assign byte_count   = count_q;
    assign odd_err      = err_q;

endmodule

// File: tb/tb_nibble_assembler.sv
// Testbench for nibble_assembler: directed scenarios plus a randomized
// phase, checked every cycle against a queue-based behavioural model.
module tb_nibble_assembler;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] nib_in = '0;
    logic       nib_valid = 1'b0;
    logic       nib_last = 1'b0;
    logic       byte_ready = 1'b0;
    logic       clr_err = 1'b0;

    logic       nib_ready;
    logic [7:0] byte_out;
    logic       byte_last;
    logic       byte_partial;
    logic       byte_valid;
    logic [15:0] byte_count;
    logic       odd_err;

    logic       w_nib_ready;
    logic [7:0] w_byte_out;
    logic       w_byte_last;
    logic       w_byte_partial;
    logic       w_byte_valid;
    logic [1:0] w_byte_count;
    logic       w_odd_err;

    always #5 clk = ~clk;

    nibble_assembler #(.NIB_W(4), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .nib_in(nib_in), .nib_valid(nib_valid),
        .nib_last(nib_last), .nib_ready(nib_ready), .byte_out(byte_out),
        .byte_last(byte_last), .byte_partial(byte_partial),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_count(byte_count), .odd_err(odd_err), .clr_err(clr_err)
    );

    // Narrow-counter copy fed the same stimulus, used to observe wrapping.
    nibble_assembler #(.NIB_W(4), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .nib_in(nib_in), .nib_valid(nib_valid),
        .nib_last(nib_last), .nib_ready(w_nib_ready), .byte_out(w_byte_out),
        .byte_last(w_byte_last), .byte_partial(w_byte_partial),
        .byte_valid(w_byte_valid), .byte_ready(byte_ready),
        .byte_count(w_byte_count), .odd_err(w_odd_err), .clr_err(clr_err)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       p;
    } ent_t;

    ent_t        mq[$];
    ent_t        obs[$];
    ent_t        m_last_pop = '0;
    bit          m_have_lo = 1'b0;
    logic [3:0]  m_lo = '0;
    int unsigned m_count = 0;
    bit          m_err = 1'b0;
    bit          m_en = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes are formed from the nibble rules and held in a
    // plain queue whose head is what downstream must see.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_last_pop = '0;
            m_have_lo  = 1'b0;
            m_lo       = '0;
            m_count    = 0;
            m_err      = 1'b0;
            m_en       = 1'b0;
        end else begin
            bit rdy;
            bit take;
            bit acc;
            bit set;
            rdy  = m_en && (mq.size() < DEPTH);
            take = (mq.size() > 0) && byte_ready;
            acc  = nib_valid && rdy;
            set  = 1'b0;
            if (take) m_last_pop = mq.pop_front();
            if (acc) begin
                if (!m_have_lo) begin
                    if (nib_last) begin
                        mq.push_back({4'h0, nib_in, 1'b1, 1'b1});
                        m_count++;
                        set = 1'b1;
                    end else begin
                        m_have_lo = 1'b1;
                        m_lo      = nib_in;
                    end
                end else begin
                    mq.push_back({nib_in, m_lo, nib_last, 1'b0});
                    m_count++;
                    m_have_lo = 1'b0;
                end
            end
            if (set) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
            m_en = 1'b1;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        ent_t exp_head;
        bit   exp_ready;
        exp_head  = (mq.size() > 0) ? mq[0] : m_last_pop;
        exp_ready = rst_n && m_en && (mq.size() < DEPTH);
        checkOutput("nib_ready", {31'd0, nib_ready}, {31'd0, exp_ready});
        checkOutput("byte_valid", {31'd0, byte_valid}, {31'd0, mq.size() > 0});
        checkOutput("head", {22'd0, byte_out, byte_last, byte_partial}, {22'd0, exp_head});
        checkOutput("byte_count", {16'd0, byte_count}, m_count % 65536);
        checkOutput("byte_count_w", {30'd0, w_byte_count}, m_count % 4);
        checkOutput("odd_err", {31'd0, odd_err}, {31'd0, m_err});
        if (byte_valid && byte_ready) obs.push_back({byte_out, byte_last, byte_partial});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one nibble and holds it until the handshake completes.
    task automatic applyStimulus(input logic [3:0] n, input logic l);
        nib_in    = n;
        nib_last  = l;
        nib_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (nib_ready) begin
                @(posedge clk);
                #1;
                nib_valid = 1'b0;
                nib_last  = 1'b0;
                return;
            end
        end
        checkOutput("nib_accept_timeout", 32'd0, 32'd1);
        nib_valid = 1'b0;
        nib_last  = 1'b0;
    endtask

    task automatic checkObs(input int idx, input logic [7:0] d, input logic l, input logic p);
        if (idx < obs.size())
            checkOutput($sformatf("obs[%0d]", idx), {22'd0, obs[idx]}, {22'd0, d, l, p});
        else
            checkOutput($sformatf("obs[%0d]_missing", idx), obs.size(), idx + 1);
    endtask

    task automatic doReset();
        #2 rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        checkOutput("rst_byte_out", {24'd0, byte_out}, 32'd0);
        checkOutput("rst_byte_count", {16'd0, byte_count}, 32'd0);
        checkOutput("rst_odd_err", {31'd0, odd_err}, 32'd0);
        checkOutput("rst_nib_ready", {31'd0, nib_ready}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Simple stream, downstream always ready.
        byte_ready = 1'b1;
        obs.delete();
        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'hA, 1'b0);
        applyStimulus(4'h3, 1'b0);
        applyStimulus(4'hC, 1'b0);
        tick(3);
        checkObs(0, 8'hA5, 1'b0, 1'b0);
        checkObs(1, 8'hC3, 1'b0, 1'b0);
        checkOutput("count_after_2", {16'd0, byte_count}, 32'd2);
        checkOutput("err_after_2", {31'd0, odd_err}, 32'd0);

        // Odd-length frame produces a padded closing byte.
        obs.delete();
        applyStimulus(4'h1, 1'b0);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h7, 1'b1);
        tick(3);
        checkObs(0, 8'h21, 1'b0, 1'b0);
        checkObs(1, 8'h07, 1'b1, 1'b1);
        checkOutput("err_after_odd", {31'd0, odd_err}, 32'd1);
        checkOutput("count_after_odd", {16'd0, byte_count}, 32'd4);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checkOutput("err_cleared", {31'd0, odd_err}, 32'd0);

        // Backpressure: FIFO fills, fifth nibble stalls, then drains in order.
        obs.delete();
        byte_ready = 1'b0;
        applyStimulus(4'h1, 1'b0);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h3, 1'b0);
        applyStimulus(4'h4, 1'b0);
        nib_in    = 4'h5;
        nib_valid = 1'b1;
        tick(3);
        checkOutput("stall_nib_ready", {31'd0, nib_ready}, 32'd0);
        byte_ready = 1'b1;
        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'h6, 1'b0);
        tick(4);
        checkObs(0, 8'h21, 1'b0, 1'b0);
        checkObs(1, 8'h43, 1'b0, 1'b0);
        checkObs(2, 8'h65, 1'b0, 1'b0);
        checkOutput("obs_count", obs.size(), 32'd3);

        // Asynchronous reset mid-frame discards the held low nibble.
        obs.delete();
        applyStimulus(4'h9, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_byte_out", {24'd0, byte_out}, 32'd0);
        checkOutput("arst_byte_valid", {31'd0, byte_valid}, 32'd0);
        checkOutput("arst_count", {16'd0, byte_count}, 32'd0);
        checkOutput("arst_nib_ready", {31'd0, nib_ready}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        applyStimulus(4'h4, 1'b0);
        applyStimulus(4'h8, 1'b0);
        tick(3);
        checkObs(0, 8'h84, 1'b0, 1'b0);

        // Padded push coinciding with clr_err: set wins.
        obs.delete();
        clr_err = 1'b1;
        applyStimulus(4'h3, 1'b1);
        clr_err = 1'b0;
        tick(2);
        checkOutput("collision_err", {31'd0, odd_err}, 32'd1);
        checkObs(0, 8'h03, 1'b1, 1'b1);

        // Counter wrap on the 2-bit instance.
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(4'(i), 1'b0);
        tick(3);
        checkOutput("wrap_count_w", {30'd0, w_byte_count}, 32'd1);
        checkOutput("wrap_count", {16'd0, byte_count}, 32'd5);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            nib_valid  = ($urandom_range(0, 3) != 0);
            nib_in     = 4'($urandom_range(0, 15));
            nib_last   = ($urandom_range(0, 3) == 0);
            byte_ready = ($urandom_range(0, 2) != 0);
            clr_err    = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        nib_valid  = 1'b0;
        nib_last   = 1'b0;
        clr_err    = 1'b0;
        byte_ready = 1'b1;
        tick(5);
        checkOutput("drained", {31'd0, byte_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
